// File: rtl/regs_pkg.sv
// Shared register-file geometry for the writeback scheduler and its picker.
package regs_pkg;
    localparam int NUM_REGS   = 8;
    localparam int REG_AW     = 3;
    localparam int REG_DW     = 8;
    localparam int NUM_WPORTS = 4;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;
endpackage

// File: rtl/regs_wb_arbiter_rr_conflict_picker.sv
// Combinational round-robin scan: grants up to NPORTS requesters per cycle,
// skipping any whose target register was already granted this cycle.
module rr_conflict_picker
    import regs_pkg::*;
#(
    parameter int NREQ   = 6,
    parameter int NPORTS = NUM_WPORTS,
    parameter int AW     = REG_AW,
    localparam int PW    = $clog2(NREQ),
    localparam int PIW   = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int CW    = $clog2(NPORTS + 1)
) (
    input  logic [PW-1:0]        rr_ptr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      grant,
    output logic [NPORTS-1:0]    port_used,
    output logic [NPORTS*PW-1:0] port_sel,
    output logic [PW-1:0]        next_ptr
);

    logic [PW:0]         sum;
    logic [PW-1:0]       idx;
    logic [AW-1:0]       addr;
    logic [CW-1:0]       cnt;
    logic [(1<<AW)-1:0]  taken;

    always_comb begin
        grant     = '0;
        port_used = '0;
        port_sel  = '0;
        next_ptr  = rr_ptr;
        taken     = '0;
        cnt       = '0;
        sum       = '0;
        idx       = '0;
        addr      = '0;
        for (int j = 0; j < NREQ; j++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(j);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx  = sum[PW-1:0];
            addr = req_addr[idx*AW +: AW];
            // taken[] holds addresses already granted; a later hit must wait
            if (req_valid[idx] && (cnt < CW'(NPORTS)) && !taken[addr]) begin
                grant[idx]                        = 1'b1;
                port_used[cnt[PIW-1:0]]           = 1'b1;
                port_sel[cnt[PIW-1:0]*PW +: PW]   = idx;
                taken[addr]                       = 1'b1;
                cnt                               = cnt + 1'b1;
                next_ptr = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback scheduler: shares the register-file write ports among NREQ requesters.
// Optional stall counter enabled by defining REGS_WB_STALL_CNT_EN.
module regs_wb_arbiter
    import regs_pkg::*;
#(
    parameter int NREQ   = 6,
    parameter int NPORTS = NUM_WPORTS,
    parameter int AW     = REG_AW,
    parameter int DW     = REG_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NPORTS-1:0]    wen,
    output logic [NPORTS*AW-1:0] waddr,
    output logic [NPORTS*DW-1:0] wdata,
    output logic [(1<<AW)-1:0]   pend_mask,
    output logic [15:0]          stall_cnt
);

    localparam int PW = $clog2(NREQ);
    localparam int NR = 1 << AW;

    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NPORTS-1:0]    wen_q, wen_d;
    logic [NPORTS*AW-1:0] waddr_q, waddr_d;
    logic [NPORTS*DW-1:0] wdata_q, wdata_d;
    logic [NR-1:0]        pend_mask_q, pend_mask_d;

    logic [NREQ-1:0]      grant;
    logic [NPORTS-1:0]    port_used;
    logic [NPORTS*PW-1:0] port_sel;
    logic [PW-1:0]        next_ptr;
    logic [PW-1:0]        sel;
    logic [AW-1:0]        sel_addr;

    rr_conflict_picker #(
        .NREQ   (NREQ),
        .NPORTS (NPORTS),
        .AW     (AW)
    ) u_picker (
        .rr_ptr    (rr_ptr_q),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .grant     (grant),
        .port_used (port_used),
        .port_sel  (port_sel),
        .next_ptr  (next_ptr)
    );

    always_comb begin
        req_ready   = rst ? '0 : grant;
        rr_ptr_d    = next_ptr;
        wen_d       = port_used;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pend_mask_d = '0;
        sel         = '0;
        sel_addr    = '0;
        // idle ports keep their last address/data so only wen toggles
        for (int k = 0; k < NPORTS; k++) begin
            sel = port_sel[k*PW +: PW];
            if (port_used[k]) begin
                sel_addr                = req_addr[sel*AW +: AW];
                waddr_d[k*AW +: AW]     = sel_addr;
                wdata_d[k*DW +: DW]     = req_data[sel*DW +: DW];
                pend_mask_d[sel_addr]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wen_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pend_mask_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pend_mask_q <= pend_mask_d;
        end
    end

    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign pend_mask = pend_mask_q;

`ifdef REGS_WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_any;

    always_comb begin
        stall_any   = |(req_valid & ~grant);
        stall_cnt_d = stall_cnt_q;
        if (stall_any && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: stimulus pushes expected write-port
// state, a monitor pops and compares it one cycle after each grant.
module tb_regs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  req_valid;
    logic [17:0] req_addr;
    logic [47:0] req_data;
    logic [5:0]  req_ready;
    logic [3:0]  wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  pend_mask;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int          id;
        logic [3:0]  wen;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [7:0]  pend;
    } exp_t;

    exp_t exp_q[$];

    regs_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .pend_mask (pend_mask),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pa(input int a0, a1, a2, a3, a4, a5);
        return {3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [47:0] pd(input int d0, d1, d2, d3, d4, d5);
        return {8'(d5), 8'(d4), 8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    function automatic logic [11:0] pwa(input int a0, a1, a2, a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [31:0] pwd(input int d0, d1, d2, d3);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, id, act, exp);
        end
    endtask

    // One request cycle: drive at negedge, check the combinational grant,
    // queue the write-port state expected after the next posedge.
    task automatic step(input int id, input logic [5:0] v, input logic [17:0] a, input logic [47:0] d,
                        input logic [5:0] er, input logic [3:0] ew, input logic [11:0] ea,
                        input logic [31:0] ed, input logic [7:0] ep);
        exp_t e;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        chk("req_ready", id, 64'(req_ready), 64'(er));
        e.id = id; e.wen = ew; e.waddr = ea; e.wdata = ed; e.pend = ep;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wen",       e.id, 64'(wen),       64'(e.wen));
                chk("waddr",     e.id, 64'(waddr),     64'(e.waddr));
                chk("wdata",     e.id, 64'(wdata),     64'(e.wdata));
                chk("pend_mask", e.id, 64'(pend_mask), 64'(e.pend));
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst       = 1'b1;
        req_valid = 6'b111111;
        req_addr  = pa(0, 1, 2, 3, 4, 5);
        req_data  = pd(1, 2, 3, 4, 5, 6);
        #1;
        chk("rst_ready",  0, 64'(req_ready), 64'h0);
        chk("rst_wen",    0, 64'(wen),       64'h0);
        chk("rst_waddr",  0, 64'(waddr),     64'h0);
        chk("rst_wdata",  0, 64'(wdata),     64'h0);
        chk("rst_pend",   0, 64'(pend_mask), 64'h0);
        chk("rst_stall",  0, 64'(stall_cnt), 64'h0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;

        // single request
        step(1,  6'b000001, pa(7,0,0,0,0,0), pd('h5A,0,0,0,0,0),
             6'b000001, 4'b0001, pwa(7,0,0,0), pwd('h5A,0,0,0), 8'h80);
        // rr_ptr=1: only req 5, pointer wraps back to 0
        step(2,  6'b100000, pa(0,0,0,0,0,2), pd(0,0,0,0,0,'h11),
             6'b100000, 4'b0001, pwa(2,0,0,0), pwd('h11,0,0,0), 8'h04);
        // all six distinct, four ports
        step(3,  6'b111111, pa(0,1,2,3,4,5), pd('h10,'h11,'h12,'h13,'h14,'h15),
             6'b001111, 4'b1111, pwa(0,1,2,3), pwd('h10,'h11,'h12,'h13), 8'h0F);
        step(4,  6'b110000, pa(0,1,2,3,4,5), pd('h10,'h11,'h12,'h13,'h14,'h15),
             6'b110000, 4'b0011, pwa(4,5,2,3), pwd('h14,'h15,'h12,'h13), 8'h30);
        // idle: address/data hold, wen and mask clear
        step(5,  6'b000000, pa(0,0,0,0,0,0), pd(0,0,0,0,0,0),
             6'b000000, 4'b0000, pwa(4,5,2,3), pwd('h14,'h15,'h12,'h13), 8'h00);
        // same-address conflict on reg 3
        step(6,  6'b000110, pa(0,3,3,0,0,0), pd(0,'hA1,'hA2,0,0,0),
             6'b000010, 4'b0001, pwa(3,5,2,3), pwd('hA1,'h15,'h12,'h13), 8'h08);
        step(7,  6'b000100, pa(0,3,3,0,0,0), pd(0,'hA1,'hA2,0,0,0),
             6'b000100, 4'b0001, pwa(3,5,2,3), pwd('hA2,'h15,'h12,'h13), 8'h08);
        // move pointer to 5
        step(8,  6'b010000, pa(0,0,0,0,6,0), pd(0,0,0,0,'h44,0),
             6'b010000, 4'b0001, pwa(6,5,2,3), pwd('h44,'h15,'h12,'h13), 8'h40);
        // rr_ptr=5: scan 5 then 0
        step(9,  6'b100001, pa(1,0,0,0,0,0), pd('hB0,0,0,0,0,'hB5),
             6'b100001, 4'b0011, pwa(0,1,2,3), pwd('hB5,'hB0,'h12,'h13), 8'h03);
        // rr_ptr=1 with paired conflicts on 2,4,6
        step(10, 6'b111111, pa(2,2,4,4,6,6), pd('hC0,'hC1,'hC2,'hC3,'hC4,'hC5),
             6'b010110, 4'b0111, pwa(2,4,6,3), pwd('hC1,'hC2,'hC4,'h13), 8'h54);
        step(11, 6'b101001, pa(2,2,4,4,6,6), pd('hC0,'hC1,'hC2,'hC3,'hC4,'hC5),
             6'b101001, 4'b0111, pwa(6,2,4,3), pwd('hC5,'hC0,'hC3,'h13), 8'h54);
        // rr_ptr=4: full load, then reset while all four ports are writing
        step(12, 6'b111111, pa(0,1,2,3,4,5), pd('h20,'h21,'h22,'h23,'h24,'h25),
             6'b110011, 4'b1111, pwa(4,5,0,1), pwd('h24,'h25,'h20,'h21), 8'h33);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen",   13, 64'(wen),       64'h0);
        chk("mid_rst_pend",  13, 64'(pend_mask), 64'h0);
        chk("mid_rst_ready", 13, 64'(req_ready), 64'h0);
        chk("mid_rst_waddr", 13, 64'(waddr),     64'h0);
        chk("mid_rst_stall", 13, 64'(stall_cnt), 64'h0);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;

        // rr_ptr back at 0: req 0 before req 5
        step(14, 6'b100001, pa(1,0,0,0,0,6), pd('hD0,0,0,0,0,'hD5),
             6'b100001, 4'b0011, pwa(1,6,0,0), pwd('hD0,'hD5,0,0), 8'h42);
        step(15, 6'b000000, pa(0,0,0,0,0,0), pd(0,0,0,0,0,0),
             6'b000000, 4'b0000, pwa(1,6,0,0), pwd('hD0,'hD5,0,0), 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 16, 64'(exp_q.size()), 64'h0);

        // stall accounting: six requesters held for ten edges
        @(negedge clk);
        req_valid = 6'b111111;
        req_addr  = pa(0, 1, 2, 3, 4, 5);
        req_data  = pd(1, 2, 3, 4, 5, 6);
        repeat (10) @(posedge clk);
        #1;
`ifdef REGS_WB_STALL_CNT_EN
        chk("stall_10", 17, 64'(stall_cnt), 64'd10);
        repeat (65524) @(posedge clk);
        #1;
        chk("stall_fffe", 18, 64'(stall_cnt), 64'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_sat", 19, 64'(stall_cnt), 64'hFFFF);
`else
        chk("stall_off", 17, 64'(stall_cnt), 64'h0);
`endif
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
